// File: rtl/rename_pkg.sv
// Shared definitions for the rename allocation scheduler.
// Provides the default widths used by the scheduler and its name FIFO, the
// one-bit lane index type used for round-robin priority, and a helper that
// returns the opposite lane.
package rename_pkg;

  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned NAME_WIDTH = 6;
  localparam int unsigned DEPTH      = 16;
  localparam int unsigned CNT_WIDTH  = 5;

  typedef enum logic [0:0] {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_e;

  // Lane that should be favoured after the given lane was served.
  function automatic lane_e other_lane(input lane_e lane);
    lane_e res;
    case (lane)
      LANE0:   res = LANE1;
      LANE1:   res = LANE0;
      default: res = LANE0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rename_name_fifo.sv
// In-order commit queue of allocated physical names.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset (pointers/count only)
//   push_i/push_data_i write a name at the tail (ignored when full)
//   pop_i              advance the head (ignored when empty)
//   pop_data_o         name at the head; meaningful only when not empty
//   count_o            occupancy; full_o / empty_o derive from it alone
module rename_name_fifo
  import rename_pkg::*;
#(
  parameter int unsigned name_width = NAME_WIDTH,
  parameter int unsigned depth      = DEPTH,
  parameter int unsigned cnt_width  = CNT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [name_width-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [name_width-1:0] pop_data_o,
  output logic [cnt_width-1:0]  count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned PTR_W = $clog2(depth);

  logic [name_width-1:0] mem_q [depth];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [cnt_width-1:0]  count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full_o     = (count_q == cnt_width'(depth));
  assign empty_o    = (count_q == {cnt_width{1'b0}});
  assign count_o    = count_q;
  assign pop_data_o = mem_q[head_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointer and occupancy next-state; pointers wrap naturally at depth.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_ok) begin
      tail_d = tail_q + 1'b1;
    end else begin
      tail_d = tail_q;
    end
    if (pop_ok) begin
      head_d = head_q + 1'b1;
    end else begin
      head_d = head_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      count_q <= {cnt_width{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Name storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[tail_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/rename_alloc_sched.sv
// Scheduler in front of the rename register file.
// Round-robin arbitrates two decode lanes onto the file's single allocation
// port, records each granted name in an in-order commit queue, and turns
// each commit into a registered free one cycle later.
// Ports:
//   CLK, RST                    clock, synchronous active-low reset
//   REQx_EN/ADDR/GRANT/NAME     lane x request, grant (combinational), name
//   RF_ALLOC_ADDR/E             allocation request to the rename file
//   RF_ALLOC_READY/RF_NAME_OUT  file has a free name / that name
//   COMMIT_E/READY/NAME         retire oldest rename / queue non-empty / head
//   RF_NAME_F/RF_FE             registered free request to the file
//   COUNT/FULL/EMPTY            commit queue occupancy
module rename_alloc_sched
  import rename_pkg::*;
#(
  parameter int unsigned addr_width = ADDR_WIDTH,
  parameter int unsigned name_width = NAME_WIDTH,
  parameter int unsigned depth      = DEPTH,
  parameter int unsigned cnt_width  = CNT_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0_EN,
  input  logic [addr_width-1:0] REQ0_ADDR,
  output logic                  REQ0_GRANT,
  output logic [name_width-1:0] REQ0_NAME,
  input  logic                  REQ1_EN,
  input  logic [addr_width-1:0] REQ1_ADDR,
  output logic                  REQ1_GRANT,
  output logic [name_width-1:0] REQ1_NAME,
  output logic [addr_width-1:0] RF_ALLOC_ADDR,
  output logic                  RF_ALLOC_E,
  input  logic                  RF_ALLOC_READY,
  input  logic [name_width-1:0] RF_NAME_OUT,
  input  logic                  COMMIT_E,
  output logic                  COMMIT_READY,
  output logic [name_width-1:0] COMMIT_NAME,
  output logic [name_width-1:0] RF_NAME_F,
  output logic                  RF_FE,
  output logic [cnt_width-1:0]  COUNT,
  output logic                  FULL,
  output logic                  EMPTY
);

  lane_e                 prio_q, prio_d;
  logic                  rf_fe_q;
  logic [name_width-1:0] rf_name_f_q;
  logic                  alloc_ok;
  logic                  gnt0, gnt1, any_gnt, pop;

  // FULL gates grants even if a commit pops this cycle, so COMMIT_E never
  // reaches the grant logic combinationally.
  assign alloc_ok = RF_ALLOC_READY && !FULL;

  // Round-robin arbitration: at most one grant per cycle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (alloc_ok && REQ0_EN && REQ1_EN) begin
      if (prio_q == LANE0) begin
        gnt0 = 1'b1;
      end else begin
        gnt1 = 1'b1;
      end
    end else if (alloc_ok && REQ0_EN) begin
      gnt0 = 1'b1;
    end else if (alloc_ok && REQ1_EN) begin
      gnt1 = 1'b1;
    end else begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  assign any_gnt       = gnt0 || gnt1;
  assign REQ0_GRANT    = gnt0;
  assign REQ1_GRANT    = gnt1;
  assign REQ0_NAME     = RF_NAME_OUT;
  assign REQ1_NAME     = RF_NAME_OUT;
  assign RF_ALLOC_E    = any_gnt;
  assign RF_ALLOC_ADDR = gnt1 ? REQ1_ADDR : REQ0_ADDR;

  // After a grant the other lane gets priority; otherwise priority holds.
  always_comb begin
    prio_d = prio_q;
    if (any_gnt) begin
      prio_d = other_lane(gnt1 ? LANE1 : LANE0);
    end else begin
      prio_d = prio_q;
    end
  end

  assign pop          = COMMIT_E && !EMPTY;
  assign COMMIT_READY = !EMPTY;
  assign RF_FE        = rf_fe_q;
  assign RF_NAME_F    = rf_name_f_q;

  // Priority and free-request registers; RF_NAME_F holds between frees.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      prio_q      <= LANE0;
      rf_fe_q     <= 1'b0;
      rf_name_f_q <= {name_width{1'b0}};
    end else begin
      prio_q  <= prio_d;
      rf_fe_q <= pop;
      if (pop) begin
        rf_name_f_q <= COMMIT_NAME;
      end
    end
  end

  rename_name_fifo #(
    .name_width(name_width),
    .depth     (depth),
    .cnt_width (cnt_width)
  ) u_fifo (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .push_i     (any_gnt),
    .push_data_i(RF_NAME_OUT),
    .pop_i      (pop),
    .pop_data_o (COMMIT_NAME),
    .count_o    (COUNT),
    .full_o     (FULL),
    .empty_o    (EMPTY)
  );

endmodule

// File: tb/tb_rename_alloc_sched.sv
module tb_rename_alloc_sched;

  logic       CLK = 1'b0;
  logic       RST, REQ0_EN, REQ1_EN, RF_ALLOC_READY, COMMIT_E;
  logic [4:0] REQ0_ADDR, REQ1_ADDR;
  logic [5:0] RF_NAME_OUT;
  logic       REQ0_GRANT, REQ1_GRANT, RF_ALLOC_E, COMMIT_READY, RF_FE, FULL, EMPTY;
  logic [5:0] REQ0_NAME, REQ1_NAME, COMMIT_NAME, RF_NAME_F;
  logic [4:0] RF_ALLOC_ADDR, COUNT;

  always #5 CLK = ~CLK;

  rename_alloc_sched dut (
    .CLK(CLK), .RST(RST),
    .REQ0_EN(REQ0_EN), .REQ0_ADDR(REQ0_ADDR), .REQ0_GRANT(REQ0_GRANT), .REQ0_NAME(REQ0_NAME),
    .REQ1_EN(REQ1_EN), .REQ1_ADDR(REQ1_ADDR), .REQ1_GRANT(REQ1_GRANT), .REQ1_NAME(REQ1_NAME),
    .RF_ALLOC_ADDR(RF_ALLOC_ADDR), .RF_ALLOC_E(RF_ALLOC_E), .RF_ALLOC_READY(RF_ALLOC_READY),
    .RF_NAME_OUT(RF_NAME_OUT), .COMMIT_E(COMMIT_E), .COMMIT_READY(COMMIT_READY),
    .COMMIT_NAME(COMMIT_NAME), .RF_NAME_F(RF_NAME_F), .RF_FE(RF_FE),
    .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY)
  );

  int checks = 0;
  int failures = 0;

  // Reference model / scoreboard: names queued at grant, popped at commit.
  logic       prio_m = 1'b0;
  logic [5:0] fifo_m[$];
  logic       free_pend_m = 1'b0;
  logic [5:0] free_name_m = 6'd0;

  // Values observed in the last driven cycle and what the model expected.
  logic       obs_g0, obs_g1, obs_ae, obs_cr, obs_full, obs_empty, obs_fe;
  logic [4:0] obs_aa, obs_cnt;
  logic [5:0] obs_n0, obs_n1, obs_cn, obs_fn;
  logic       exp_g0, exp_g1, exp_fe;
  logic [4:0] exp_aa;
  logic [5:0] exp_fn, exp_cn;
  int         exp_cnt;

  // Drive one cycle of inputs, sample outputs on the falling edge, then
  // advance the model across the rising edge.
  task automatic drive(input logic rst, input logic r0, input logic [4:0] a0,
                       input logic r1, input logic [4:0] a1, input logic rdy,
                       input logic [5:0] nm, input logic cm);
    logic ok, do_pop;
    RST = rst; REQ0_EN = r0; REQ0_ADDR = a0; REQ1_EN = r1; REQ1_ADDR = a1;
    RF_ALLOC_READY = rdy; RF_NAME_OUT = nm; COMMIT_E = cm;
    @(negedge CLK);
    obs_g0 = REQ0_GRANT; obs_g1 = REQ1_GRANT; obs_ae = RF_ALLOC_E; obs_aa = RF_ALLOC_ADDR;
    obs_n0 = REQ0_NAME; obs_n1 = REQ1_NAME; obs_cr = COMMIT_READY; obs_cn = COMMIT_NAME;
    obs_cnt = COUNT; obs_full = FULL; obs_empty = EMPTY; obs_fe = RF_FE; obs_fn = RF_NAME_F;
    ok      = rdy && (fifo_m.size() < 16);
    exp_g0  = ok && r0 && (!r1 || prio_m == 1'b0);
    exp_g1  = ok && r1 && (!r0 || prio_m == 1'b1);
    exp_aa  = exp_g1 ? a1 : a0;
    exp_fe  = free_pend_m;
    exp_fn  = free_name_m;
    exp_cnt = fifo_m.size();
    exp_cn  = (fifo_m.size() > 0) ? fifo_m[0] : 6'd0;
    do_pop  = cm && (fifo_m.size() > 0);
    @(posedge CLK);
    #1;
    if (!rst) begin
      fifo_m.delete();
      prio_m = 1'b0; free_pend_m = 1'b0; free_name_m = 6'd0;
    end else begin
      if (do_pop) begin
        free_name_m = fifo_m.pop_front();
        free_pend_m = 1'b1;
      end else begin
        free_pend_m = 1'b0;
      end
      if (exp_g0 || exp_g1) begin
        fifo_m.push_back(nm);
        prio_m = exp_g0 ? 1'b1 : 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 6'd0, 1'b0);
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 6'd0, 1'b0);
    checks++; if (obs_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b want=1", obs_empty); end
    checks++; if (obs_cnt !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", obs_cnt); end
    checks++; if (obs_full !== 1'b0 || obs_cr !== 1'b0) begin failures++; $display("FAIL reset_full_ready got=%b%b want=00", obs_full, obs_cr); end
    checks++; if (obs_fe !== 1'b0 || obs_fn !== 6'd0) begin failures++; $display("FAIL reset_free got=%b/%0d want=0/0", obs_fe, obs_fn); end
    checks++; if (obs_g0 !== 1'b0 || obs_g1 !== 1'b0 || obs_ae !== 1'b0) begin failures++; $display("FAIL reset_grant got=%b%b%b want=000", obs_g0, obs_g1, obs_ae); end
  endtask

  task automatic test_arbitration;
    logic [5:0] nm;
    for (int i = 0; i < 3; i++) begin
      nm = 6'd32 + 6'(i);
      drive(1'b1, 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, nm, 1'b0);
      // Spec sequence: lane0, lane1, lane0.
      checks++; if (obs_g0 !== (i != 1) || obs_g1 !== (i == 1)) begin failures++; $display("FAIL arb_grant[%0d] got=%b%b want=%b%b", i, obs_g0, obs_g1, (i != 1), (i == 1)); end
      checks++; if (obs_ae !== 1'b1 || obs_aa !== ((i == 1) ? 5'd7 : 5'd3)) begin failures++; $display("FAIL arb_alloc[%0d] got=%b/%0d", i, obs_ae, obs_aa); end
      checks++; if ((i == 1 ? obs_n1 : obs_n0) !== nm) begin failures++; $display("FAIL arb_name[%0d] got=%0d want=%0d", i, (i == 1 ? obs_n1 : obs_n0), nm); end
    end
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 6'd0, 1'b0);
    checks++; if (obs_cnt !== 5'd3) begin failures++; $display("FAIL arb_count got=%0d want=3", obs_cnt); end
  endtask

  task automatic test_commit;
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 6'd0, 1'b1);
    checks++; if (obs_cr !== 1'b1 || obs_cn !== 6'd32) begin failures++; $display("FAIL commit_head0 got=%b/%0d want=1/32", obs_cr, obs_cn); end
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 6'd0, 1'b1);
    checks++; if (obs_cn !== 6'd33) begin failures++; $display("FAIL commit_head1 got=%0d want=33", obs_cn); end
    checks++; if (obs_fe !== 1'b1 || obs_fn !== 6'd32) begin failures++; $display("FAIL commit_free0 got=%b/%0d want=1/32", obs_fe, obs_fn); end
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 6'd0, 1'b0);
    checks++; if (obs_fe !== 1'b1 || obs_fn !== 6'd33) begin failures++; $display("FAIL commit_free1 got=%b/%0d want=1/33", obs_fe, obs_fn); end
    checks++; if (obs_cnt !== 5'd1) begin failures++; $display("FAIL commit_count got=%0d want=1", obs_cnt); end
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 6'd0, 1'b0);
    checks++; if (obs_fe !== 1'b0 || obs_fn !== 6'd33) begin failures++; $display("FAIL commit_hold got=%b/%0d want=0/33", obs_fe, obs_fn); end
  endtask

  task automatic test_full;
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 1'b1, 5'(i), 1'b0, 5'd0, 1'b1, 6'(i + 1), 1'b0);
      checks++; if (obs_g0 !== 1'b1 || obs_aa !== 5'(i)) begin failures++; $display("FAIL fill_grant[%0d] got=%b/%0d", i, obs_g0, obs_aa); end
    end
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 6'd0, 1'b0);
    checks++; if (obs_full !== 1'b1 || obs_cnt !== 5'd16) begin failures++; $display("FAIL full_flag got=%b/%0d want=1/16", obs_full, obs_cnt); end
    drive(1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b1, 6'd50, 1'b1);
    checks++; if (obs_g0 !== 1'b0 || obs_ae !== 1'b0) begin failures++; $display("FAIL full_block got=%b%b want=00", obs_g0, obs_ae); end
    drive(1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b1, 6'd51, 1'b0);
    checks++; if (obs_cnt !== 5'd15 || obs_g0 !== 1'b1) begin failures++; $display("FAIL full_regrant got=%0d/%b want=15/1", obs_cnt, obs_g0); end
    for (int i = 0; i < 20 && fifo_m.size() > 0; i++) begin
      drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 6'd0, 1'b1);
      checks++; if (obs_cn !== exp_cn || obs_cnt !== 5'(exp_cnt)) begin failures++; $display("FAIL drain_head[%0d] got=%0d/%0d want=%0d/%0d", i, obs_cn, obs_cnt, exp_cn, exp_cnt); end
      checks++; if (obs_fe !== exp_fe || obs_fn !== exp_fn) begin failures++; $display("FAIL drain_free[%0d] got=%b/%0d want=%b/%0d", i, obs_fe, obs_fn, exp_fe, exp_fn); end
    end
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 6'd0, 1'b0);
    checks++; if (obs_fe !== 1'b1 || obs_fn !== 6'd51 || obs_empty !== 1'b1) begin failures++; $display("FAIL drain_last got=%b/%0d/%b want=1/51/1", obs_fe, obs_fn, obs_empty); end
  endtask

  task automatic test_not_ready;
    drive(1'b1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 6'd60, 1'b0);
    checks++; if (obs_g0 !== 1'b0 || obs_g1 !== 1'b0 || obs_ae !== 1'b0) begin failures++; $display("FAIL notready_grant got=%b%b%b want=000", obs_g0, obs_g1, obs_ae); end
    // Last grant went to lane 0, so lane 1 must now win.
    drive(1'b1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 6'd61, 1'b0);
    checks++; if (obs_g1 !== 1'b1 || obs_g0 !== 1'b0 || obs_aa !== 5'd2) begin failures++; $display("FAIL notready_prio got=%b%b/%0d want=01/2", obs_g0, obs_g1, obs_aa); end
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 6'd0, 1'b1);
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 6'd0, 1'b1);
    checks++; if (obs_fe !== 1'b1 || obs_fn !== 6'd61) begin failures++; $display("FAIL notready_free got=%b/%0d want=1/61", obs_fe, obs_fn); end
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 6'd0, 1'b0);
    checks++; if (obs_fe !== 1'b0 || obs_empty !== 1'b1) begin failures++; $display("FAIL empty_commit got=%b/%b want=0/1", obs_fe, obs_empty); end
  endtask

  task automatic test_wrap_and_reset;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 1'b1, 5'(i), 1'b0, 5'd0, 1'b1, 6'(i % 64), 1'b1);
      checks++; if (obs_g0 !== 1'b1) begin failures++; $display("FAIL wrap_grant[%0d] got=%b want=1", i, obs_g0); end
      checks++; if (obs_fe !== exp_fe || (exp_fe && obs_fn !== exp_fn)) begin failures++; $display("FAIL wrap_free[%0d] got=%b/%0d want=%b/%0d", i, obs_fe, obs_fn, exp_fe, exp_fn); end
      if (i >= 1) begin
        // Push+pop each cycle: occupancy stays at one; frees follow push order.
        checks++; if (obs_cnt !== 5'd1 || obs_cn !== 6'(i - 1)) begin failures++; $display("FAIL wrap_head[%0d] got=%0d/%0d want=1/%0d", i, obs_cnt, obs_cn, i - 1); end
      end
    end
    for (int i = 0; i < 8 && fifo_m.size() < 5; i++) begin
      drive(1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 1'b1, 6'(10 + i), 1'b0);
    end
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 6'd0, 1'b0);
    checks++; if (obs_cnt !== 5'd5) begin failures++; $display("FAIL prereset_count got=%0d want=5", obs_cnt); end
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 6'd0, 1'b1);
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 6'd0, 1'b1);
    checks++; if (obs_empty !== 1'b1 || obs_cnt !== 5'd0) begin failures++; $display("FAIL midreset_empty got=%b/%0d want=1/0", obs_empty, obs_cnt); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (obs_fe !== 1'b0) begin failures++; $display("FAIL midreset_nofree[%0d] got=%b want=0", i, obs_fe); end
      drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 6'd0, 1'b1);
    end
  endtask

  initial begin
    RST = 1'b0; REQ0_EN = 1'b0; REQ1_EN = 1'b0; REQ0_ADDR = 5'd0; REQ1_ADDR = 5'd0;
    RF_ALLOC_READY = 1'b0; RF_NAME_OUT = 6'd0; COMMIT_E = 1'b0;
    test_reset();
    test_arbitration();
    test_commit();
    test_full();
    test_not_ready();
    test_wrap_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
